// File: rtl/mem_pkg.sv
// Shared definitions for the packet-buffer controllers: block geometry,
// the linked-list footer carried in the low 16 bits of every block, FSM states.
package mem_pkg;

    localparam int ADDR_W     = 8;
    localparam int BLOCK_BITS = 64;
    localparam int FOOTER_W   = 16;

    typedef struct packed {
        logic                         eop;
        logic [FOOTER_W-2-ADDR_W:0]   rsvd;
        logic [ADDR_W-1:0]            next_idx;
    } footer_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/memory_write_ctrl.sv
// Write side of the linked-list packet buffer: pops a free block per accepted beat,
// writes each block with its chain footer and reports head/length on end of packet.
module memory_write_ctrl #(
    parameter int ADDR_W     = mem_pkg::ADDR_W,
    parameter int BLOCK_BITS = mem_pkg::BLOCK_BITS,
    parameter int LEN_W      = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BLOCK_BITS-1:0] data_i,
    input  logic                  data_valid_i,
    input  logic                  data_eop_i,
    output logic                  data_ready_o,
    input  logic                  alloc_valid_i,
    input  logic [ADDR_W-1:0]     alloc_idx_i,
    output logic                  alloc_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_waddr_o,
    output logic [BLOCK_BITS-1:0] mem_wdata_o,
    output logic                  pkt_valid_o,
    output logic [ADDR_W-1:0]     pkt_head_o,
    output logic [LEN_W-1:0]      pkt_len_o
);
    import mem_pkg::*;

    localparam int LINK_W = FOOTER_W - 1;
    localparam logic [BLOCK_BITS-1:0] PAYLOAD_MASK = ~{{(BLOCK_BITS-FOOTER_W){1'b0}}, {FOOTER_W{1'b1}}};
    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    wr_state_e               state_r;
    wr_state_e               state_s;
    logic [ADDR_W-1:0]       cur_idx_r;
    logic [ADDR_W-1:0]       cur_idx_s;
    logic [ADDR_W-1:0]       head_idx_r;
    logic [ADDR_W-1:0]       head_idx_s;
    logic [LEN_W-1:0]        len_cnt_r;
    logic [LEN_W-1:0]        len_cnt_s;
    logic [LEN_W-1:0]        len_inc_s;
    logic                    have_cur_s;
    logic                    data_ready_s;
    logic                    alloc_ready_s;
    logic                    beat_s;
    footer_t                 footer_s;
    logic [FOOTER_W-1:0]     footer_bits_s;

    logic                    mem_we_r;
    logic                    mem_we_s;
    logic [ADDR_W-1:0]       mem_waddr_r;
    logic [ADDR_W-1:0]       mem_waddr_s;
    logic [BLOCK_BITS-1:0]   mem_wdata_r;
    logic [BLOCK_BITS-1:0]   mem_wdata_s;
    logic                    pkt_valid_r;
    logic                    pkt_valid_s;
    logic [ADDR_W-1:0]       pkt_head_r;
    logic [ADDR_W-1:0]       pkt_head_s;
    logic [LEN_W-1:0]        pkt_len_r;
    logic [LEN_W-1:0]        pkt_len_s;

    assign have_cur_s = (state_r != ST_EMPTY);
    assign beat_s     = data_valid_i & data_ready_s;
    assign len_inc_s  = (len_cnt_r == LEN_MAX) ? len_cnt_r : len_cnt_r + LEN_W'(1);

    // Handshake: prefetch a block while empty, otherwise pair each beat with one pop.
    always_comb begin
        data_ready_s  = 1'b0;
        alloc_ready_s = 1'b0;
        if (!have_cur_s) begin
            // a pop during reset would be lost, so hold the free list off
            alloc_ready_s = alloc_valid_i & rst_n;
        end else begin
            data_ready_s  = alloc_valid_i;
            alloc_ready_s = data_valid_i & alloc_valid_i;
        end
    end

    // Next state, chain bookkeeping and the registered memory/report outputs.
    always_comb begin
        state_s       = state_r;
        cur_idx_s     = cur_idx_r;
        head_idx_s    = head_idx_r;
        len_cnt_s     = len_cnt_r;
        mem_we_s      = 1'b0;
        mem_waddr_s   = mem_waddr_r;
        mem_wdata_s   = mem_wdata_r;
        pkt_valid_s   = 1'b0;
        pkt_head_s    = pkt_head_r;
        pkt_len_s     = pkt_len_r;
        footer_s      = footer_t'({data_eop_i, data_eop_i ? {LINK_W{1'b0}} : LINK_W'(alloc_idx_i)});
        footer_bits_s = footer_s;
        case (state_r)
            ST_EMPTY: begin
                if (alloc_valid_i && alloc_ready_s) begin
                    cur_idx_s = alloc_idx_i;
                    state_s   = ST_IDLE;
                end else begin
                    state_s   = ST_EMPTY;
                end
            end
            ST_IDLE, ST_BUSY: begin
                if (beat_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = cur_idx_r;
                    mem_wdata_s = (data_i & PAYLOAD_MASK) | {{(BLOCK_BITS-FOOTER_W){1'b0}}, footer_bits_s};
                    cur_idx_s   = alloc_idx_i;
                    if (data_eop_i) begin
                        pkt_valid_s = 1'b1;
                        pkt_head_s  = (state_r == ST_IDLE) ? cur_idx_r : head_idx_r;
                        pkt_len_s   = (state_r == ST_IDLE) ? LEN_W'(1) : len_inc_s;
                        state_s     = ST_IDLE;
                    end else if (state_r == ST_IDLE) begin
                        head_idx_s = cur_idx_r;
                        len_cnt_s  = LEN_W'(1);
                        state_s    = ST_BUSY;
                    end else begin
                        len_cnt_s  = len_inc_s;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
    end

    // State and output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            cur_idx_r   <= '0;
            head_idx_r  <= '0;
            len_cnt_r   <= '0;
            mem_we_r    <= 1'b0;
            mem_waddr_r <= '0;
            mem_wdata_r <= '0;
            pkt_valid_r <= 1'b0;
            pkt_head_r  <= '0;
            pkt_len_r   <= '0;
        end else begin
            state_r     <= state_s;
            cur_idx_r   <= cur_idx_s;
            head_idx_r  <= head_idx_s;
            len_cnt_r   <= len_cnt_s;
            mem_we_r    <= mem_we_s;
            mem_waddr_r <= mem_waddr_s;
            mem_wdata_r <= mem_wdata_s;
            pkt_valid_r <= pkt_valid_s;
            pkt_head_r  <= pkt_head_s;
            pkt_len_r   <= pkt_len_s;
        end
    end

    assign data_ready_o  = data_ready_s;
    assign alloc_ready_o = alloc_ready_s;
    assign mem_we_o      = mem_we_r;
    assign mem_waddr_o   = mem_waddr_r;
    assign mem_wdata_o   = mem_wdata_r;
    assign pkt_valid_o   = pkt_valid_r;
    assign pkt_head_o    = pkt_head_r;
    assign pkt_len_o     = pkt_len_r;

endmodule

// File: tb/tb_memory_write_ctrl.sv
// Bench for memory_write_ctrl: queue-based free-list/packet model, directed scenarios
// with literal expectations, then randomized traffic; a second instance uses LEN_W=3.
module tb_memory_write_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] data = 64'd0;
    logic        dv = 1'b0;
    logic        eop = 1'b0;
    logic        av = 1'b0;
    logic [7:0]  aidx = 8'd0;

    logic        dr, ar, we, pv;
    logic [7:0]  waddr, phead;
    logic [63:0] wdata;
    logic [11:0] plen;
    logic        dr3, ar3, we3, pv3;
    logic [7:0]  waddr3, phead3;
    logic [63:0] wdata3;
    logic [2:0]  plen3;

    memory_write_ctrl #(.ADDR_W(8), .BLOCK_BITS(64), .LEN_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data), .data_valid_i(dv), .data_eop_i(eop),
        .data_ready_o(dr), .alloc_valid_i(av), .alloc_idx_i(aidx), .alloc_ready_o(ar),
        .mem_we_o(we), .mem_waddr_o(waddr), .mem_wdata_o(wdata),
        .pkt_valid_o(pv), .pkt_head_o(phead), .pkt_len_o(plen));

    memory_write_ctrl #(.ADDR_W(8), .BLOCK_BITS(64), .LEN_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .data_i(data), .data_valid_i(dv), .data_eop_i(eop),
        .data_ready_o(dr3), .alloc_valid_i(av), .alloc_idx_i(aidx), .alloc_ready_o(ar3),
        .mem_we_o(we3), .mem_waddr_o(waddr3), .mem_wdata_o(wdata3),
        .pkt_valid_o(pv3), .pkt_head_o(phead3), .pkt_len_o(plen3));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // behavioural model
    bit          have_cur;
    logic [7:0]  cur, mhead;
    int          blk;
    bit          av_en;
    logic [7:0]  nf = 8'd100;
    logic [7:0]  fl[$];
    logic [63:0] pay_q[$];
    logic [63:0] walk_q[$];
    logic [63:0] dmem [256];
    bit          e_we, e_pv;
    logic [7:0]  e_addr, e_head;
    logic [63:0] e_data;
    int          e_len, e_len3;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero();
        chk("rst_dready", dr, 0);
        chk("rst_aready", ar, 0);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_pv", pv, 0);
        chk("rst_head", phead, 0);
        chk("rst_len", plen, 0);
        chk("rst_aready3", ar3, 0);
        chk("rst_we3", we3, 0);
    endtask

    task automatic refill();
        while (fl.size() < 4) begin
            fl.push_back(nf);
            nf = nf + 8'd1;
        end
    endtask

    // one clock cycle: called just after a rising edge with stimulus fields set
    task automatic step();
        bit         e_dr, e_ar;
        logic [7:0] nxt, idx;
        logic [63:0] w;
        av   = av_en && (fl.size() != 0);
        aidx = (fl.size() != 0) ? fl[0] : 8'd0;
        #1;
        e_dr = have_cur && av;
        e_ar = have_cur ? (dv && av) : av;
        chk("data_ready", dr, e_dr);
        chk("alloc_ready", ar, e_ar);
        chk("data_ready3", dr3, e_dr);
        chk("alloc_ready3", ar3, e_ar);
        @(posedge clk);
        e_we = 1'b0;
        e_pv = 1'b0;
        if (av && e_ar) begin
            nxt = fl.pop_front();
            if (!have_cur) begin
                have_cur = 1'b1;
            end else begin
                e_we   = 1'b1;
                e_addr = cur;
                e_data = {data[63:16], eop, 7'd0, (eop ? 8'd0 : nxt)};
                pay_q.push_back(data);
                if (blk == 0) mhead = cur;
                blk++;
                if (eop) begin
                    e_pv   = 1'b1;
                    e_head = mhead;
                    e_len  = (blk > 4095) ? 4095 : blk;
                    e_len3 = (blk > 7) ? 7 : blk;
                    walk_q = pay_q;
                    pay_q.delete();
                    blk = 0;
                end
            end
            cur = nxt;
        end
        #1;
        chk("mem_we", we, e_we);
        chk("mem_we3", we3, e_we);
        chk("pkt_valid", pv, e_pv);
        chk("pkt_valid3", pv3, e_pv);
        if (e_we) begin
            chk("mem_waddr", waddr, e_addr);
            chk("mem_wdata", wdata, e_data);
            chk("mem_wdata3", wdata3, e_data);
        end
        if (we) dmem[waddr] = wdata;
        if (e_pv) begin
            chk("pkt_head", phead, e_head);
            chk("pkt_len", plen, e_len);
            chk("pkt_head3", phead3, e_head);
            chk("pkt_len3", plen3, e_len3);
            idx = e_head;
            for (int i = 0; i < walk_q.size(); i++) begin
                w = dmem[idx];
                chk("chain_data", w[63:16], walk_q[i][63:16]);
                chk("chain_eop", w[15], (i == walk_q.size() - 1));
                chk("chain_rsvd", w[14:8], 0);
                idx = w[7:0];
            end
        end
    endtask

    task automatic drive(input bit d, input bit e, input bit a);
        dv    = d;
        eop   = e;
        av_en = a;
        data  = {$urandom, $urandom};
        step();
    endtask

    // called just after a rising edge; asserts reset between edges
    task automatic do_reset();
        #2;
        av = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_zero();
        have_cur = 1'b0;
        blk = 0;
        pay_q.delete();
        fl.delete();
        e_we = 1'b0;
        e_pv = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        have_cur = 1'b0;
        blk = 0;
        av_en = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // single-block packet, then a back-to-back single-block packet
        fl = '{8'd5, 8'd9, 8'd6};
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        chk("t1_addr", waddr, 8'd5);
        chk("t1_footer", wdata[15:0], 16'h8000);
        chk("t1_head", phead, 8'd5);
        chk("t1_len", plen, 12'd1);
        drive(1'b1, 1'b1, 1'b1);
        chk("t4_we", we, 1'b1);
        chk("t4_addr", waddr, 8'd9);
        chk("t4_head", phead, 8'd9);

        // three-block packet back to back
        do_reset();
        fl = '{8'd3, 8'd7, 8'd2, 8'd4};
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        chk("t2_addr0", waddr, 8'd3);
        chk("t2_foot0", wdata[15:0], 16'h0007);
        chk("t2_payload", wdata[63:16], data[63:16]);
        drive(1'b1, 1'b0, 1'b1);
        chk("t2_addr1", waddr, 8'd7);
        chk("t2_foot1", wdata[15:0], 16'h0002);
        drive(1'b1, 1'b1, 1'b1);
        chk("t2_addr2", waddr, 8'd2);
        chk("t2_foot2", wdata[15:0], 16'h8000);
        chk("t2_head", phead, 8'd3);
        chk("t2_len", plen, 12'd3);

        // free list empties mid-packet
        fl = '{8'd11, 8'd12, 8'd13};
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk("t3_stall_we", we, 1'b0);
            chk("t3_stall_ready", dr, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        chk("t3_head", phead, 8'd4);
        chk("t3_len", plen, 12'd3);

        // ten-block packet: LEN_W=3 instance clamps
        for (int i = 0; i < 10; i++) fl.push_back(8'(20 + i));
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        chk("t5_len3", plen3, 3'd7);
        chk("t5_len", plen, 12'd10);
        chk("t5_head", phead, 8'd13);

        // reset mid-packet, then recovery prefetch
        fl = '{8'd40, 8'd41};
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        do_reset();
        fl = '{8'd50, 8'd51, 8'd52};
        drive(1'b1, 1'b0, 1'b1);
        chk("t6_no_write", we, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        chk("t6_addr", waddr, 8'd50);
        chk("t6_head", phead, 8'd50);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            refill();
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_write_ctrl.md
# memory_write_ctrl

Write-side companion of the packet-buffer read controller. Accepts a packet from a producer as a stream of fixed-size blocks, takes a free block index from the free list for every accepted block, and writes each block with its linked-list footer (`next_idx`, `eop`) into the shared packet memory. On the last block it reports the packet's head index and block count to the queueing logic. The read controller later follows these chains back out.

## Interface
- `ADDR_W`, default `mem_pkg::ADDR_W`: block index width; must be ≤ 15.
- `BLOCK_BITS`, default `mem_pkg::BLOCK_BITS`: block width including the 16-bit footer.
- `LEN_W`, default 12: packet length counter width, in blocks.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `data_i`  in  BLOCK_BITS  block from producer; bits [15:0] are ignored and replaced by the footer.
- `data_valid_i`  in  1  producer has a block.
- `data_eop_i`  in  1  this block is the last of its packet.
- `data_ready_o`  out  1  block accepted when valid & ready.
- `alloc_valid_i`  in  1  free list has a block available.
- `alloc_idx_i`  in  ADDR_W  index of that block.
- `alloc_ready_o`  out  1  pop; the free list advances on valid & ready.
- `mem_we_o`  out  1  memory write strobe.
- `mem_waddr_o`  out  ADDR_W  write address.
- `mem_wdata_o`  out  BLOCK_BITS  write data.
- `pkt_valid_o`  out  1  one-cycle pulse: a packet is fully written.
- `pkt_head_o`  out  ADDR_W  head block index of that packet.
- `pkt_len_o`  out  LEN_W  block count of that packet.

## Operation
- **State register `cur_idx`** (plus flag `have_cur`): the block index the next accepted beat is written to.
- **Packet registers:** `head_idx` and `len_cnt`.
- **FSM states:**
  - `EMPTY`: reset state; `have_cur`=0.
  - `IDLE`: `cur_idx` held, between packets.
  - `BUSY`: mid-packet.
- **EMPTY:**
  - `alloc_ready_o` = `alloc_valid_i`; `data_ready_o` = 0.
  - On a pop: `cur_idx` ← `alloc_idx_i`, go to IDLE.
- **IDLE/BUSY:**
  - `data_ready_o` = `alloc_valid_i`.
  - `alloc_ready_o` = `data_valid_i` & `alloc_valid_i`.
  - Every accepted beat pops exactly one free block, which becomes `nxt`.
- **Accepted beat, `data_eop_i`=0:**
  - Write `{data_i[BLOCK_BITS-1:16], footer{eop=0, rsvd=0, next_idx=nxt}}` to `cur_idx`.
  - `cur_idx` ← `nxt`.
  - If IDLE: `head_idx` ← `cur_idx`, `len_cnt` ← 1, go to BUSY.
  - If BUSY: `len_cnt`++.
- **Accepted beat, `data_eop_i`=1:**
  - Write the footer with eop=1, next_idx=0.
  - `cur_idx` ← `nxt` (pre-allocation for the next packet, no bubble).
  - Pulse `pkt_valid_o` with head = (IDLE ? `cur_idx` : `head_idx`) and len = (IDLE ? 1 : `len_cnt`+1).
  - Go to IDLE.
- **Free list empty:** `data_ready_o` = 0, including on an eop beat. This is pure backpressure with no data loss.
- **Length saturation:** `len_cnt` saturates at 2^LEN_W−1. The chain is still written correctly; only the reported length clamps.
- **Footer layout:** the low 16 bits of each block are `{eop[15], rsvd[14:ADDR_W], next_idx[ADDR_W-1:0]}`. This is the exact layout the read side decodes.
- **Reset mid-packet:** all state clears. The partial chain and `cur_idx` are leaked; the free list is reset in the same domain, so no recovery is required.

## Timing
- **Reset values:**
  - `data_ready_o`, `alloc_ready_o`, `mem_we_o`, `pkt_valid_o` = 0.
  - `mem_waddr_o`, `mem_wdata_o`, `pkt_head_o`, `pkt_len_o` = 0.
- **Handshake-side outputs are combinational:** `data_ready_o` and `alloc_ready_o` are functions of state, `alloc_valid_i` and `data_valid_i`. `data_ready_o` never depends on `data_valid_i`.
- **Memory-side outputs are registered:** all `mem_*` and `pkt_*` outputs.
  - A beat accepted at edge t produces `mem_we_o`=1 with its address and data during cycle t+1.
  - For an eop beat, `pkt_valid_o` pulses in that same cycle t+1.
  - `mem_we_o` is low in any cycle following an edge with no accepted beat.
- **Throughput:** one block per cycle while `alloc_valid_i` stays high.
- **Post-reset latency:** the first beat can be accepted one cycle after the first `alloc_valid_i`, because the EMPTY prefetch takes one cycle.

## Structure
- **`mem_pkg` contents:** `footer_t` (packed 16-bit: `eop`, `rsvd`, `next_idx`), `FOOTER_W`=16, `ADDR_W`, `BLOCK_BITS`. `footer_t` is shared unchanged with the read controller.
- **Packing:** footer packing goes through `footer_t` casts only.
- **Module structure:** single module, no sub-module. The FSM, index/length registers and output register stage are all in `memory_write_ctrl`.

## Test plan
Bench parameters: `ADDR_W`=8, `BLOCK_BITS`=64, `LEN_W`=12.
1. **Single-block packet.** Free list supplies 5 then 9; send one beat with eop.
   - Expect one write to addr 5 with footer eop=1, next=0.
   - Expect `pkt_valid_o` with head=5, len=1; `cur_idx`=9 afterward.
2. **Three-block packet, back-to-back.** Free list supplies 3, 7, 2, 4.
   - Expect writes to 3 (next=7), 7 (next=2), 2 (eop=1) on consecutive cycles.
   - Expect a packet report with head=3, len=3.
   - Expect `data_i[63:16]` preserved in each write and `data_i[15:0]` replaced by the footer.
3. **Free list empties mid-packet.** Drop `alloc_valid_i` for 4 cycles during the second beat.
   - Expect `data_ready_o`=0 and no `mem_we_o` for those 4 cycles.
   - On resume, expect the chain intact and len=3.
4. **Back-to-back packets with eop followed by a new first beat.**
   - Expect no bubble.
   - Expect the second packet's head equal to the index popped on the first packet's eop beat.
5. **Length saturation.** With `LEN_W`=3, send a 10-block packet.
   - Expect reported len=7.
   - Expect all 10 footers chained correctly.
6. **Asynchronous reset.** Assert `rst_n` low mid-packet, between clock edges.
   - Expect all outputs 0 immediately and FSM in EMPTY.
   - After release, expect the first `alloc_valid_i` to be popped into `cur_idx` with `data_ready_o` still 0 for that cycle.
